// File: rtl/seq_scan_ctrl.sv
// Frame controller: serialises valid/ready words MSB-first and counts pattern matches.
// Define SEQ_ABORT_EN to add the abort input for early frame termination.
module seq_scan_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W  = $clog2(DATA_W);
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [DATA_W-1:0]  shreg_q;
    logic               last_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PAT_W-2:0]   hist_q;
    logic [PAT_W-2:0]   hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               in_ready_q;
    logic               bit_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [PAT_W-1:0]   window;
    logic               match_w;
    logic               abort_w;

`ifdef SEQ_ABORT_EN
    assign abort_w = abort & (state_q != S_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Window is the last PAT_W-1 bits plus the bit on the wire right now.
    assign window  = {hist_q, shreg_q[DATA_W-1]};
    assign match_w = bit_valid_q && (fill_q == FILL_MAX)
                     && (window == pat_q) && !abort_w;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (bit_valid_q) begin
            if (match_w && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
        if (match_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            ovl_q       <= 1'b0;
            shreg_q     <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_w) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        pat_q      <= cfg_pattern;
                        ovl_q      <= cfg_overlap;
                        cnt_q      <= '0;
                        hist_q     <= '0;
                        fill_q     <= '0;
                        state_q    <= S_WAIT;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        shreg_q     <= in_data;
                        last_q      <= in_last;
                        idx_q       <= IDX_MAX;
                        state_q     <= S_SHIFT;
                        in_ready_q  <= 1'b0;
                        bit_valid_q <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shreg_q << 1;
                    idx_q   <= idx_q - 1'b1;
                    hist_q  <= hist_d;
                    fill_q  <= fill_d;
                    cnt_q   <= cnt_d;
                    if (idx_q == '0) begin
                        bit_valid_q <= 1'b0;
                        if (last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign bit_out     = shreg_q[DATA_W-1];
    assign bit_valid   = bit_valid_q;
    assign match       = match_w;
    assign match_count = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: default instance plus a CNT_W=2 instance.
// Both instances share stimulus; the narrow one checks counter saturation.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
`ifdef SEQ_ABORT_EN
    logic       abort;
`endif

    logic       a_in_ready, a_bit_out, a_bit_valid, a_match, a_busy, a_done;
    logic [7:0] a_match_count;
    logic       b_in_ready, b_bit_out, b_bit_valid, b_match, b_busy, b_done;
    logic [1:0] b_match_count;

    always #5 clk = ~clk;

    seq_scan_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(a_in_ready), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
        .match(a_match), .match_count(a_match_count),
        .busy(a_busy), .done(a_done)
    );

    seq_scan_ctrl #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(b_in_ready), .bit_out(b_bit_out), .bit_valid(b_bit_valid),
        .match(b_match), .match_count(b_match_count),
        .busy(b_busy), .done(b_done)
    );

    typedef struct packed {
        logic b;
        logic m;
    } bit_t;

    bit_t exp_q[$];
    int   cnt_q[$];
    int   cntb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic chk_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected bits/counts whenever the DUT presents them.
    always @(negedge clk) begin
        bit_t e;
        if (chk_busy) begin
            chk("busy_after_done", 32'(a_busy), 32'd0);
            chk_busy = 1'b0;
        end
        if (a_bit_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bit_out", 32'(a_bit_out), 32'(e.b));
                chk("match", 32'(a_match), 32'(e.m));
            end
        end else begin
            chk("match_no_bit", 32'(a_match), 32'd0);
        end
        if (a_done) begin
            if (cnt_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("match_count", 32'(a_match_count), cnt_q.pop_front());
                chk("bits_left_at_done", exp_q.size(), 32'd0);
                chk_busy = 1'b1;
            end
        end
        if (b_done) begin
            if (cntb_q.size() == 0) begin
                chk("unexpected_done_sat", 32'd1, 32'd0);
            end else begin
                chk("match_count_sat", 32'(b_match_count), cntb_q.pop_front());
            end
        end
    end

    task automatic run_frame(input logic [3:0] pat, input logic ovl,
                             input int n, input logic [23:0] words,
                             input logic [23:0] masks, input int cnt,
                             input bit poke);
        logic [7:0] w;
        logic [7:0] m;
        int t;
        cnt_q.push_back(cnt);
        cntb_q.push_back(cnt > 3 ? 3 : cnt);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_overlap = ovl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_pattern = ~pat;
        cfg_overlap = ~ovl;
        chk("busy_in_wait", 32'(a_busy), 32'd1);
        chk("ready_in_wait", 32'(a_in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            w = words[23-8*i -: 8];
            m = masks[23-8*i -: 8];
            for (int j = 7; j >= 0; j--) begin
                exp_q.push_back('{b: w[j], m: m[j]});
            end
            in_valid = 1'b1;
            in_data  = w;
            in_last  = (i == n - 1);
            t = 0;
            while (!a_in_ready && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (!a_in_ready) chk("accept_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            if (i == n - 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            chk("first_bit_latency", 32'(a_bit_valid), 32'd1);
            if (poke && i == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        t = 0;
        while (!a_done && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!a_done) chk("done_timeout", 32'd1, 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst = 1'b0;
        start = 1'b0;
        cfg_pattern = 4'h0;
        cfg_overlap = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
`ifdef SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        chk("reset_outputs",
            32'({a_in_ready, a_bit_valid, a_match, a_busy, a_done}), 32'd0);
        chk("reset_count", 32'(a_match_count), 32'd0);
        chk("reset_count_sat", 32'(b_match_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_frame(4'b1010, 1'b1, 1, {8'hAA, 16'h0}, {8'h15, 16'h0}, 3, 1'b0);
        run_frame(4'b1010, 1'b0, 1, {8'hAA, 16'h0}, {8'h11, 16'h0}, 2, 1'b0);
        run_frame(4'b1010, 1'b1, 2, {8'h01, 8'h40, 8'h0},
                  {8'h00, 8'h20, 8'h0}, 1, 1'b0);
        run_frame(4'b0000, 1'b1, 1, {8'h00, 16'h0}, {8'h1F, 16'h0}, 5, 1'b0);
        run_frame(4'b0000, 1'b0, 1, {8'h00, 16'h0}, {8'h11, 16'h0}, 2, 1'b0);
        run_frame(4'b1010, 1'b1, 3, {8'hAA, 8'hAA, 8'hAA},
                  {8'h15, 8'h55, 8'h55}, 11, 1'b0);

        // Reset pulse on the third bit of a frame.
        @(negedge clk);
        cfg_pattern = 4'b1010;
        cfg_overlap = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 7; j >= 0; j--) begin
            exp_q.push_back('{b: j[0] ? 1'b1 : 1'b0, m: (j < 5) && !j[0]});
        end
        in_valid = 1'b1;
        in_data = 8'hAA;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            32'({a_in_ready, a_bit_valid, a_match, a_busy, a_done}), 32'd0);
        chk("midframe_reset_count", 32'(a_match_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        run_frame(4'b1010, 1'b1, 1, {8'hAA, 16'h0}, {8'h15, 16'h0}, 3, 1'b1);

`ifdef SEQ_ABORT_EN
        @(negedge clk);
        cfg_pattern = 4'b1010;
        cfg_overlap = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 7; j >= 0; j--) begin
            exp_q.push_back('{b: j[0] ? 1'b1 : 1'b0, m: (j < 5) && !j[0]});
        end
        in_valid = 1'b1;
        in_data = 8'hAA;
        in_last = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!a_in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!a_in_ready) chk("abort_wait_timeout", 32'd1, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_ready", 32'(a_in_ready), 32'd0);
        chk("abort_count", 32'(a_match_count), 32'd3);
        chk("abort_count_sat", 32'(b_match_count), 32'd3);
        repeat (4) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("queues_drained", exp_q.size() + cnt_q.size() + cntb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Frame-level controller for the serial 4-bit sequence detector.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first into a bit stream.
- Runs a programmable pattern match on that stream and counts matches per frame.
- Signals frame completion to the host side.
- Sits between a byte-wide producer and the detection/status logic, replacing hand-driven bit stimulus.

Parameters:
DATA_W, 8, width of input words (bits shifted per word)
PAT_W, 4, pattern length in bits (>=2, <=DATA_W)
CNT_W, 8, width of match counter (saturating)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle frame start request, honoured only in IDLE
cfg_pattern  input  PAT_W  pattern to detect, MSB = first bit in time
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
in_valid  input  1  producer word valid
in_data  input  DATA_W  producer word
in_last  input  1  word is last of frame, qualified by in_valid
in_ready  output  1  controller can accept a word
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out meaningful this cycle
match  output  1  pattern completed on this cycle's bit (Mealy, combinational from state + shift reg)
match_count  output  CNT_W  matches in current/last frame
busy  output  1  frame in progress (not IDLE)
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all registers and outputs 0.
  - in_ready, bit_valid, match, busy, done = 0; match_count = 0.
- FSM states:
  - IDLE: in_ready=0, busy=0.
    - start=1 -> latch cfg_pattern and cfg_overlap into shadow regs.
    - Clear match_count, pattern history and fill counter.
    - Go to WAIT.
  - WAIT: in_ready=1, busy=1.
    - On in_valid&in_ready -> load shift reg with in_data, latch in_last, bit index = DATA_W-1.
    - Go to SHIFT.
  - SHIFT: in_ready=0, bit_valid=1, bit_out = shift reg MSB.
    - Each cycle, shift left and decrement index.
    - When the index reaches 0 (DATA_W-th bit): go to DONE if last latched, else WAIT.
  - DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Config and start rules:
  - cfg_* are sampled only at start; mid-frame changes have no effect.
  - start outside IDLE is ignored.
- Latency and throughput:
  - Word accepted at edge k -> its bits appear on cycles k+1 .. k+DATA_W.
  - Throughput is one word per DATA_W+1 cycles.
  - WAIT can stall indefinitely; bit_valid=0 while stalled.
- Pattern history: PAT_W-1 bits, plus a fill counter saturating at PAT_W-1. Both persist across word boundaries within a frame.
- Match condition: match = bit_valid & (fill==PAT_W-1) & ({history, bit_out}==pattern).
- Update on each bit_valid cycle:
  - No match, or match with overlap=1: shift bit into history and increment fill (saturating).
  - Match with overlap=0: clear history and fill to 0.
- match_count:
  - Increments on every match cycle and saturates at all-ones (no wrap).
  - Holds its value in IDLE/DONE until the next accepted start.
- Simultaneous events: in_valid during SHIFT is not accepted (in_ready=0); the producer must hold it.
- Reset mid-frame: immediate return to IDLE, count cleared, partial word discarded.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state -> IDLE at the next edge, no done pulse.
  - match_count retains its value; match is forced 0 during the abort cycle.
  - abort has priority over in_valid handshakes and over the SHIFT->DONE/WAIT transitions.
- Undefined: no abort port; a frame ends only via in_last or reset.

Test Plan:
1. pattern=1010, overlap=1, one word 0xAA with last.
   - match pulses on bits 4, 6, 8; match_count=3.
   - done pulses 1 cycle after bit 8; busy drops the cycle after.
2. Same as 1 with overlap=0 -> matches on bits 4 and 8 only; match_count=2.
3. Boundary crossing: pattern=1010, overlap=1, words 0x01 then 0x40(last).
   - Single match on bit 11 (3rd bit of 2nd word); match_count=1.
   - in_valid held through first SHIFT is accepted only in WAIT.
4. Fill gating: pattern=0000, word 0x00(last).
   - overlap=1 -> matches on bits 4..8, count=5.
   - overlap=0 -> matches on bits 4 and 8, count=2.
   - No match before the 4th bit.
5. Saturation: CNT_W=2, pattern=1010, overlap=1, words 0xAA, 0xAA, 0xAA(last) -> 11 matches; match_count stops at 3.
6. Reset and abort:
   - rst=0 pulse during 3rd bit of SHIFT -> all outputs 0 immediately, IDLE.
   - A new start then runs scenario 1 cleanly.
   - With SEQ_ABORT_EN: abort in WAIT -> IDLE next cycle, no done, count retained.
